// File: rtl/sp_encoder_scheduler.sv
// ---------------------------------------------------------------------------
// sp_encoder_scheduler
//
// Shares one service-protocol packet encoder between N reply requesters.
// A round-robin arbiter picks one requester, latches its packet fields into
// registers that drive the encoder, enables the encoder for the length of
// the packet (size + 4 words: 2 header words, data, CRC, packet number) and
// then forces one disabled GAP cycle so the encoder returns to its wait
// state before the next packet. Empty packets are rejected without enabling
// the encoder, and a watchdog aborts a packet whose encoder stalls.
//
// Ports
//   clk         rising-edge clock
//   nRst        synchronous active-low reset
//   req         per-requester level request, held until its done pulse
//   req_addr    per-requester packet address      (N x 8)
//   req_size    per-requester data word count     (N x 16)
//   req_cmd     per-requester command code        (N x 8)
//   grant       one-hot owner of the encoder while a packet is running
//   done        one-cycle pulse to the requester whose packet finished,
//               was rejected (size 0) or was aborted (watchdog)
//   err         one-cycle pulse coincident with done on reject / abort
//   enc_addr    encoder packet address
//   enc_size    encoder data word count
//   enc_cmd     encoder command code
//   enc_enable  encoder enable, high only while a packet is running
//   pkt_done    encoder completion pulse, one per word written
//   busy        high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module sp_encoder_scheduler #(
  parameter int N       = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0][7:0]   req_addr,
  input  logic [N-1:0][15:0]  req_size,
  input  logic [N-1:0][7:0]   req_cmd,
  output logic [N-1:0]        grant,
  output logic [N-1:0]        done,
  output logic                err,
  output logic [7:0]          enc_addr,
  output logic [15:0]         enc_size,
  output logic [7:0]          enc_cmd,
  output logic                enc_enable,
  input  logic                pkt_done,
  output logic                busy
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IW-1:0]   rr_ptr;     // first index to consider at the next ARB
  logic [IW-1:0]   owner;      // requester of the packet in flight
  logic [IW-1:0]   pick;       // arbiter choice this cycle
  logic [IW-1:0]   idx;
  logic            found;
  logic [16:0]     wcnt;       // words still expected from the encoder
  logic [WW-1:0]   wdog;       // cycles left before the stall abort
  logic            err_q;      // the packet heading into GAP ends in error
  logic            last_word;
  logic            wd_expire;

  // -------------------------------------------------------------------------
  // Round-robin arbiter: scan from rr_ptr upward, wrapping at N.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default at
    // the top so no path leaves it unassigned and infers a latch.
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // The final word is the one that takes the counter from 1 to 0; finishing
  // on that edge puts done in the very next cycle.
  assign last_word = pkt_done && (wcnt == 17'd1);
  // A pkt_done on the same cycle reloads the watchdog, so it wins.
  assign wd_expire = !pkt_done && (wdog <= WW'(1));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking (<=)
    // assignments so every register samples pre-edge values.
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|req) state_nxt = ARB;
      end
      ARB: begin
        if (!found) begin
          state_nxt = IDLE;
        end else if (req_size[pick] == 16'd0) begin
          // The encoder cannot emit an empty packet: reject it outright.
          state_nxt = GAP;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_word || wd_expire) state_nxt = GAP;
      end
      GAP: begin
        state_nxt = (|req) ? ARB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Every entry into GAP ends a packet, so done is simply the GAP
  // cycle decoded onto the owner; grant and enable are the RUN state.
  // -------------------------------------------------------------------------
  always_comb begin
    grant = '0;
    done  = '0;
    if (state == RUN) grant[owner] = 1'b1;
    if (state == GAP) done[owner]  = 1'b1;
    err        = (state == GAP) && err_q;
    enc_enable = (state == RUN);
    busy       = (state != IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath: field latches, word counter, watchdog, round-robin pointer.
  // Fields are only written in ARB, so enc_* cannot move during RUN.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nRst) begin
      // NOTE: every datapath register is cleared in reset, so the encoder
      // never sees stale fields and arbitration restarts at index 0.
      rr_ptr   <= '0;
      owner    <= '0;
      enc_addr <= '0;
      enc_size <= '0;
      enc_cmd  <= '0;
      wcnt     <= '0;
      wdog     <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            owner    <= pick;
            rr_ptr   <= (int'(pick) == N - 1) ? '0 : pick + 1'b1;
            enc_addr <= req_addr[pick];
            enc_size <= req_size[pick];
            enc_cmd  <= req_cmd[pick];
            wcnt     <= {1'b0, req_size[pick]} + 17'd4;
            wdog     <= WW'(TIMEOUT);
            err_q    <= (req_size[pick] == 16'd0);
          end
        end
        RUN: begin
          if (pkt_done) begin
            wcnt <= wcnt - 17'd1;
            wdog <= WW'(TIMEOUT);
          end else begin
            wdog <= wdog - WW'(1);
            if (wd_expire) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
